facto_master: RTL and testbench
===============================

Name: facto_master

Overview:
- Bus-master front end that sits directly upstream of the factorial core and drives its 64-bit slave register interface.
- Accepts a factorial request (operand n) on a valid/ready handshake, then runs the full programming sequence: clear, operand write, interrupt enable, start.
- Waits for completion (interrupt or status polling), reads the 128-bit result, clears the core, and returns result or timeout error on a valid/ready response port.

Parameters:
- BASE, 16'h7000, slave register base address.
- USE_IRQ, 1, 1 = wait on `m_interrupt`; 0 = poll the status register.
- TIMEOUT, 20000, maximum WAIT-state cycles before abort (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  request accepted when `cmd_valid & cmd_ready` at a rising edge.
- cmd_n  in  64  factorial operand.
- rsp_valid  out  1  response valid, held until `rsp_ready`.
- rsp_ready  in  1  response consumed.
- rsp_result  out  128  `{result_h, result_l}`.
- rsp_error  out  1  1 = timeout abort; `rsp_result` is 0.
- m_sel  out  1  slave select.
- m_wr  out  1  1 = write, 0 = read.
- m_addr  out  16  slave address.
- m_dout  out  64  write data to slave.
- m_din  in  64  read data from slave.
- m_interrupt  in  1  completion interrupt from slave.

Behaviour:
- **Register map (offsets from BASE):**
  - +0x00 opstart
  - +0x08 opclear
  - +0x10 opdone (bit 0 = done)
  - +0x18 intrEn
  - +0x20 operand
  - +0x28 result_h
  - +0x30 result_l
- **Bus timing:**
  - One access per cycle.
  - Bus outputs are a Moore function of the state register and latched data only.
  - Slave read data is combinational; `m_din` is sampled at the rising edge ending the read cycle.
  - `m_dout` = 0 on reads.
- **States:** IDLE, W_CLR, W_OPND, W_IEN, W_START, WAIT, R_H, R_L, W_CLR2, RESP.
- **IDLE:**
  - `cmd_ready` = 1, bus idle (`m_sel`/`m_wr`/`m_addr`/`m_dout` = 0).
  - On accept: latch `cmd_n`, clear the error flag and timeout counter, go to W_CLR.
- **W_CLR:** write 1 to +0x08.
- **W_OPND:** write latched n to +0x20.
- **W_IEN:** write `USE_IRQ` (as 64-bit 0/1) to +0x18.
- **W_START:** write 1 to +0x00.
- W_CLR through W_START each last exactly one cycle, in that order.
- **WAIT:**
  - `USE_IRQ`=1: bus idle; exit when `m_interrupt` = 1 at an edge.
  - `USE_IRQ`=0: read +0x10 every cycle; exit when sampled `m_din[0]` = 1.
  - Done → R_H.
  - The counter increments every WAIT cycle. If it reaches TIMEOUT with no done, set the error flag, zero the result registers, and go to W_CLR2 (skip the reads).
  - If done and timeout coincide in the same cycle, done wins.
- **R_H:** read +0x28 into `result[127:64]`.
- **R_L:** read +0x30 into `result[63:0]`.
- **W_CLR2:** write 1 to +0x08.
- **RESP:**
  - `rsp_valid` = 1; `rsp_result` and `rsp_error` stable.
  - Leave to IDLE on `rsp_ready` (may already be high on entry, giving a 1-cycle RESP).
- **Handshake and latency:**
  - `cmd_ready` = 0 in all states except IDLE; a new request cannot be accepted in the cycle RESP exits.
  - Latency with IRQ done seen in the first WAIT cycle and `rsp_ready` held high: accept edge T, W_CLR at T+1, RESP at T+9.
  - `m_interrupt` outside WAIT is ignored.
- **Reset:**
  - All regs clear at the edge with `reset` = 1: state IDLE; `cmd_ready` = 1 from the next cycle.
  - All other outputs are 0 from the next cycle, including mid-operation (no clear write issued).
- `rsp_result`/`rsp_error` hold their last values in IDLE until overwritten by the next accept.

Test Plan:
- **Reset:** hold `reset` for 2 cycles → `m_sel` = 0, `rsp_valid` = 0, `cmd_ready` = 1, `rsp_result` = 0.
- **IRQ path:**
  - Stimulus: `USE_IRQ`=1; behavioural slave asserts `m_interrupt` 10 cycles after the opstart write and returns result_h = 0, result_l = 120; `cmd_n` = 5.
  - Writes seen in order: (7008,1), (7020,5), (7018,1), (7000,1).
  - Then reads 7028, 7030, then write (7008,1).
  - Response: `rsp_result` = 120, `rsp_error` = 0.
- **Poll path:**
  - Stimulus: `USE_IRQ`=0; slave opdone reads 0 for 7 reads then 1; n = 20; slave returns result_l = 64'h21C3677C82B40000.
  - Required: exactly 8 reads of 7010 and result matches; intrEn write data = 0.
- **Timeout:** TIMEOUT = 16, slave never signals done → exactly 16 WAIT cycles, no 7028/7030 reads, clear write issued, `rsp_error` = 1, `rsp_result` = 0.
- **Backpressure:**
  - Stimulus: `rsp_ready` = 0 for 5 cycles in RESP; second `cmd_valid` held high throughout.
  - Required: `rsp_valid`/`rsp_result` stable for those 5 cycles; second command accepted only in IDLE, one cycle after the `rsp_ready` edge.
- **Reset mid-operation:** assert `reset` in WAIT → next cycle IDLE, bus idle; a fresh n = 3 request completes normally with the slave returning 6.

Source files
------------

// File: rtl/facto_master.sv
// Bus master that programs the factorial core through its 64-bit register slave,
// waits for completion (interrupt or status poll), reads the 128-bit result and reports it.
module facto_master #(
    parameter logic [15:0] BASE    = 16'h7000,
    parameter int          USE_IRQ = 1,
    parameter int          TIMEOUT = 20000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [63:0]  cmd_n,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_result,
    output logic         rsp_error,
    output logic         m_sel,
    output logic         m_wr,
    output logic [15:0]  m_addr,
    output logic [63:0]  m_dout,
    input  logic [63:0]  m_din,
    input  logic         m_interrupt
);
    localparam logic [15:0] OPSTART  = BASE + 16'h00;
    localparam logic [15:0] OPCLEAR  = BASE + 16'h08;
    localparam logic [15:0] OPDONE   = BASE + 16'h10;
    localparam logic [15:0] INTR_EN  = BASE + 16'h18;
    localparam logic [15:0] OPERAND  = BASE + 16'h20;
    localparam logic [15:0] RESULT_H = BASE + 16'h28;
    localparam logic [15:0] RESULT_L = BASE + 16'h30;

    typedef enum logic [3:0] {
        IDLE, W_CLR, W_OPND, W_IEN, W_START, WAIT, R_H, R_L, W_CLR2, RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] n_q;
    logic [31:0] wait_cnt;
    logic        done;
    logic        expired;
    logic        bus_sel;
    logic        bus_wr;
    logic [15:0] bus_addr;
    logic [63:0] bus_dout;

    always_comb begin
        done      = (USE_IRQ != 0) ? m_interrupt : m_din[0];
        expired   = (wait_cnt + 32'd1) >= 32'(TIMEOUT);
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_valid) state_nxt = W_CLR;
            W_CLR:   state_nxt = W_OPND;
            W_OPND:  state_nxt = W_IEN;
            W_IEN:   state_nxt = W_START;
            W_START: state_nxt = WAIT;
            // done takes priority over an expiring counter in the same cycle
            WAIT: begin
                if (done)         state_nxt = R_H;
                else if (expired) state_nxt = W_CLR2;
            end
            R_H:     state_nxt = R_L;
            R_L:     state_nxt = W_CLR2;
            W_CLR2:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus drive for the upcoming state, registered so outputs follow the state register.
    always_comb begin
        bus_sel  = 1'b0;
        bus_wr   = 1'b0;
        bus_addr = 16'h0;
        bus_dout = 64'h0;
        case (state_nxt)
            W_CLR, W_CLR2: begin bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = OPCLEAR; bus_dout = 64'd1; end
            W_OPND:  begin bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = OPERAND; bus_dout = n_q; end
            W_IEN: begin
                bus_sel  = 1'b1;
                bus_wr   = 1'b1;
                bus_addr = INTR_EN;
                bus_dout = (USE_IRQ != 0) ? 64'd1 : 64'd0;
            end
            W_START: begin bus_sel = 1'b1; bus_wr = 1'b1; bus_addr = OPSTART; bus_dout = 64'd1; end
            WAIT:    if (USE_IRQ == 0) begin bus_sel = 1'b1; bus_addr = OPDONE; end
            R_H:     begin bus_sel = 1'b1; bus_addr = RESULT_H; end
            R_L:     begin bus_sel = 1'b1; bus_addr = RESULT_L; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_error  <= 1'b0;
            m_sel      <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= 16'h0;
            m_dout     <= 64'h0;
            n_q        <= 64'h0;
            wait_cnt   <= 32'd0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            m_sel     <= bus_sel;
            m_wr      <= bus_wr;
            m_addr    <= bus_addr;
            m_dout    <= bus_dout;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        n_q        <= cmd_n;
                        wait_cnt   <= 32'd0;
                        rsp_error  <= 1'b0;
                        rsp_result <= '0;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 32'd1;
                    if (!done && expired) begin
                        rsp_error  <= 1'b1;
                        rsp_result <= '0;
                    end
                end
                R_H:     rsp_result[127:64] <= m_din;
                R_L:     rsp_result[63:0]   <= m_din;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_facto_master.sv
// Self-checking bench for facto_master: one IRQ-mode and one poll-mode instance driven by a
// behavioural slave, checked every cycle against a transaction-level expected bus/response trace.
module tb_facto_master;
    localparam int TO = 16;

    typedef struct packed {
        logic        sel;
        logic        wr;
        logic [15:0] addr;
        logic [63:0] dout;
    } bus_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [63:0] cmd_n = 64'h0;
    bit          act = 1'b0;

    logic [1:0]   cv, cr, rv, rr, re, ms, mw, mi;
    logic [127:0] rres [2];
    logic [15:0]  ma [2];
    logic [63:0]  mdo [2];
    logic [63:0]  mdi [2];

    int           dly = 1000;
    logic [127:0] slv_res = '0;
    logic         noise = 1'b0;
    logic [1:0]   started = '0;
    int           since [2] = '{0, 0};
    logic [1:0]   sdone;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign cv = {cmd_valid & act, cmd_valid & ~act};
    assign rr = {rsp_ready & act, rsp_ready & ~act};
    assign mi = {noise, sdone[0]};

    facto_master #(.BASE(16'h7000), .USE_IRQ(1), .TIMEOUT(TO)) dut_irq (
        .clk(clk), .reset(reset), .cmd_valid(cv[0]), .cmd_ready(cr[0]), .cmd_n(cmd_n),
        .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_result(rres[0]), .rsp_error(re[0]),
        .m_sel(ms[0]), .m_wr(mw[0]), .m_addr(ma[0]), .m_dout(mdo[0]), .m_din(mdi[0]),
        .m_interrupt(mi[0]));

    facto_master #(.BASE(16'h7000), .USE_IRQ(0), .TIMEOUT(TO)) dut_poll (
        .clk(clk), .reset(reset), .cmd_valid(cv[1]), .cmd_ready(cr[1]), .cmd_n(cmd_n),
        .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_result(rres[1]), .rsp_error(re[1]),
        .m_sel(ms[1]), .m_wr(mw[1]), .m_addr(ma[1]), .m_dout(mdo[1]), .m_din(mdi[1]),
        .m_interrupt(mi[1]));

    logic         o_cr, o_rv, o_re, o_ms, o_mw;
    logic [127:0] o_rres;
    logic [15:0]  o_ma;
    logic [63:0]  o_mdo;
    assign o_cr   = cr[act];
    assign o_rv   = rv[act];
    assign o_re   = re[act];
    assign o_ms   = ms[act];
    assign o_mw   = mw[act];
    assign o_rres = rres[act];
    assign o_ma   = ma[act];
    assign o_mdo  = mdo[act];

    // Behavioural slave: done becomes visible dly cycles after the opstart write.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) started[k] <= 1'b0;
            else if (ms[k] && mw[k] && ma[k] == 16'h7000) begin started[k] <= 1'b1; since[k] <= 1; end
            else if (ms[k] && mw[k] && ma[k] == 16'h7008) started[k] <= 1'b0;
            else if (started[k]) since[k] <= since[k] + 1;
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            sdone[k] = started[k] && (since[k] >= dly);
            mdi[k]   = '1;
            case (ma[k])
                16'h7010: mdi[k] = {63'd0, sdone[k]};
                16'h7028: mdi[k] = slv_res[127:64];
                16'h7030: mdi[k] = slv_res[63:0];
                default:  ;
            endcase
        end
    end

    always @(negedge clk) noise <= 1'($urandom_range(0, 1));

    task automatic check(input string name, input logic [128:0] av, input logic [128:0] ev);
        checks++;
        if (av !== ev) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, av, ev, $time);
        end
    endtask

    function automatic logic [127:0] fact(input int n);
        logic [127:0] r = 128'd1;
        for (int i = 2; i <= n; i++) r = r * 128'(i);
        return r;
    endfunction

    function automatic bus_t mk(input logic s, input logic w, input logic [15:0] a, input logic [63:0] d);
        return {s, w, a, d};
    endfunction

    // Reference model: expected per-cycle bus trace for one transaction plus the response.
    int           ph = 0;
    int           idx = 0;
    bus_t         q[$];
    logic [128:0] exp_rsp = '0;
    logic [128:0] last [2] = '{129'd0, 129'd0};
    bit           armed = 1'b0;

    task automatic build(input logic [63:0] n, input int d);
        bit irq = !act;
        int w = (d <= TO) ? d : TO;
        q.delete();
        q.push_back(mk(1'b1, 1'b1, 16'h7008, 64'd1));
        q.push_back(mk(1'b1, 1'b1, 16'h7020, n));
        q.push_back(mk(1'b1, 1'b1, 16'h7018, irq ? 64'd1 : 64'd0));
        q.push_back(mk(1'b1, 1'b1, 16'h7000, 64'd1));
        for (int i = 0; i < w; i++) q.push_back(irq ? mk(1'b0, 1'b0, 16'h0, 64'd0) : mk(1'b1, 1'b0, 16'h7010, 64'd0));
        if (d <= TO) begin
            q.push_back(mk(1'b1, 1'b0, 16'h7028, 64'd0));
            q.push_back(mk(1'b1, 1'b0, 16'h7030, 64'd0));
        end
        q.push_back(mk(1'b1, 1'b1, 16'h7008, 64'd1));
        exp_rsp = (d <= TO) ? {1'b0, slv_res} : {1'b1, 128'd0};
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            armed = 1'b1; ph = 0; last[0] = '0; last[1] = '0; q.delete();
        end else if (ph == 0) begin
            if (cmd_valid) begin build(cmd_n, dly); ph = 1; idx = 0; end
        end else if (ph == 1) begin
            idx++;
            if (idx == q.size()) begin ph = 2; last[act] = exp_rsp; end
        end else if (rsp_ready) begin
            ph = 0;
        end
    end

    int          busy_total = 0, poll_total = 0, rdres_total = 0, clr_total = 0;
    logic [63:0] ien_last = '0;
    bus_t        obs;

    initial forever begin
        @(negedge clk);
        if (armed) begin
            obs = {o_ms, o_mw, o_ma, o_mdo};
            if (ph == 0) begin
                check("idle_handshake", 129'({o_cr, o_rv}), 129'(2'b10));
                check("idle_bus", 129'(obs), 129'd0);
                check("idle_rsp_hold", {o_re, o_rres}, last[act]);
            end else if (ph == 1) begin
                check("busy_handshake", 129'({o_cr, o_rv}), 129'(2'b00));
                check("bus_cycle", 129'(obs), 129'(q[idx]));
            end else begin
                check("resp_handshake", 129'({o_cr, o_rv}), 129'(2'b01));
                check("resp_bus", 129'(obs), 129'd0);
                check("resp_data", {o_re, o_rres}, last[act]);
            end
            if (!o_cr && !o_rv) busy_total++;
            if (o_ms && !o_mw && o_ma == 16'h7010) poll_total++;
            if (o_ms && !o_mw && (o_ma == 16'h7028 || o_ma == 16'h7030)) rdres_total++;
            if (o_ms && o_mw && o_ma == 16'h7008) clr_total++;
            if (o_ms && o_mw && o_ma == 16'h7018) ien_last = o_mdo;
        end
    end

    logic [127:0] g_res;
    logic         g_err;
    int           g_busy, g_poll, g_rdres, g_clr;

    task automatic wait_rsp();
        int k = 0;
        while (!o_rv && k < 200) begin @(negedge clk); k++; end
        if (!o_rv) begin
            checks++; errors++;
            $display("FAIL rsp_wait: no response after %0d cycles, required rsp_valid=1", k);
        end
    endtask

    task automatic run_cmd(input logic [63:0] n, input int d, input logic [127:0] res,
                           input int hold, input bit early);
        int b0 = busy_total, p0 = poll_total, r0 = rdres_total, c0 = clr_total;
        int k = 0;
        dly = d; slv_res = res; cmd_n = n; cmd_valid = 1'b1; rsp_ready = early;
        while (!o_cr && k < 100) begin @(negedge clk); k++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp();
        g_res = o_rres; g_err = o_re;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("resp_stable", 129'({o_rv, o_re, o_rres}), 129'({1'b1, g_err, g_res}));
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        g_busy = busy_total - b0; g_poll = poll_total - p0;
        g_rdres = rdres_total - r0; g_clr = clr_total - c0;
    endtask

    task automatic set_act(input bit v);
        @(posedge clk);
        #1 act = v;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0]  n;
        logic [127:0] r;
        logic [128:0] snap;
        int           d;
        bit           nb;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 129'({o_ms, o_rv, o_cr}), 129'(3'b001));
        check("reset_result", {o_re, o_rres}, 129'd0);
        reset = 1'b0;
        @(negedge clk);

        // IRQ path: n=5, interrupt 10 cycles after opstart.
        set_act(1'b0);
        run_cmd(64'd5, 10, fact(5), 0, 1'b1);
        check("irq_result", {g_err, g_res}, {1'b0, 128'd120});
        check("irq_busy_cycles", 129'(g_busy), 129'd17);
        check("irq_result_reads", 129'(g_rdres), 129'd2);
        check("irq_clear_writes", 129'(g_clr), 129'd2);
        check("irq_intr_en", 129'(ien_last), 129'd1);

        run_cmd(64'd7, 1, fact(7), 0, 1'b1);
        check("latency_busy", 129'(g_busy), 129'd8);
        check("latency_result", {g_err, g_res}, {1'b0, 128'd5040});

        run_cmd(64'd9, 1000, fact(9), 0, 1'b1);
        check("timeout_rsp", {g_err, g_res}, {1'b1, 128'd0});
        check("timeout_busy", 129'(g_busy), 129'd21);
        check("timeout_no_reads", 129'(g_rdres), 129'd0);
        check("timeout_clears", 129'(g_clr), 129'd2);

        run_cmd(64'd6, 16, fact(6), 2, 1'b0);
        check("done_wins_rsp", {g_err, g_res}, {1'b0, 128'd720});
        check("done_wins_busy", 129'(g_busy), 129'd23);

        // Backpressure with a second request held valid throughout.
        dly = 3; slv_res = fact(4); cmd_n = 64'd4; rsp_ready = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        check("bp_accept1", 129'(o_cr), 129'd0);
        cmd_n = 64'd6;
        wait_rsp();
        snap = {o_re, o_rres};
        check("bp_first", snap, {1'b0, 128'd24});
        slv_res = fact(6);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 129'(o_rv), 129'd1);
            check("bp_hold_data", {o_re, o_rres}, snap);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_idle_ready", 129'({o_cr, o_rv}), 129'(2'b10));
        @(negedge clk);
        check("bp_accept2", 129'({o_cr, o_ms, o_mw, o_ma}), 129'({1'b0, 1'b1, 1'b1, 16'h7008}));
        cmd_valid = 1'b0;
        wait_rsp();
        check("bp_second", {o_re, o_rres}, {1'b0, 128'd720});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset while waiting for completion, then a fresh request.
        dly = 1000; cmd_n = 64'd9; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid", 129'({o_ms, o_mw, o_cr, o_rv, o_ma}), 129'({1'b0, 1'b0, 1'b1, 1'b0, 16'h0}));
        reset = 1'b0;
        run_cmd(64'd3, 4, fact(3), 1, 1'b0);
        check("after_reset_result", {g_err, g_res}, {1'b0, 128'd6});

        // Poll path.
        set_act(1'b1);
        run_cmd(64'd20, 8, fact(20), 0, 1'b1);
        check("poll_result", {g_err, g_res}, {1'b0, 128'h21C3677C82B40000});
        check("poll_reads", 129'(g_poll), 129'd8);
        check("poll_intr_en", 129'(ien_last), 129'd0);
        run_cmd(64'd11, 1000, fact(11), 0, 1'b1);
        check("poll_timeout_rsp", {g_err, g_res}, {1'b1, 128'd0});
        check("poll_timeout_reads", 129'(g_poll), 129'd16);

        // Randomized traffic on both instances.
        for (int i = 0; i < 30; i++) begin
            if (i % 6 == 0) begin
                nb = ((i / 6) % 2) == 0;
                set_act(nb);
            end
            if ($urandom_range(0, 3) == 0) begin
                n = {$urandom, $urandom};
                r = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                n = 64'($urandom_range(0, 34));
                r = fact(int'(n));
            end
            d = int'($urandom_range(1, 20));
            run_cmd(n, d, r, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            check("rnd_rsp", {g_err, g_res}, (d <= TO) ? {1'b0, r} : {1'b1, 128'd0});
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
